// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler feeding one shared ALU; ALU_SCHED_STATS_EN enables the op_count counter.
module alu_sched #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*2*DW-1:0] req_opnds,
    input  logic [NREQ*3-1:0] req_op,
    output logic [2*DW-1:0]   alu_operands,
    output logic [2:0]        alu_opcode,
    input  logic [DW-1:0]     alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_data,
    output logic [2:0]        rsp_id,
    output logic              busy,
    output logic [15:0]       op_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic [2:0] rr_ptr;
    logic [2:0] cnt;
    logic [2:0] gidx;
    logic       found;
    logic       accept;
    logic       done;

    // first valid requester at or after rr_ptr, wrapping
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int k = 0; k < NREQ; k++)
            if (!found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                found = 1'b1;
                gidx  = 3'((int'(rr_ptr) + k) % NREQ);
            end
    end

    assign accept    = state == IDLE && found;
    assign req_ready = accept ? NREQ'(1) << gidx : '0;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE;
    assign done      = rsp_valid && rsp_ready;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            cnt          <= '0;
            alu_operands <= '0;
            alu_opcode   <= '0;
            rsp_data     <= '0;
            rsp_id       <= '0;
        end else if (accept) begin
            alu_operands <= req_opnds[int'(gidx)*2*DW +: 2*DW];
            alu_opcode   <= req_op[int'(gidx)*3 +: 3];
            rsp_id       <= gidx;
            cnt          <= 3'(ALU_LAT);
            state        <= WAIT;
        end else if (state == WAIT) begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd0) begin
                rsp_data <= alu_result;
                state    <= RESP;
            end
        end else if (done) begin
            rr_ptr <= rsp_id == 3'(NREQ - 1) ? 3'd0 : rsp_id + 3'd1;
            state  <= IDLE;
        end

`ifdef ALU_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst)
        if (rst)
            op_count <= '0;
        else if (done && op_count != 16'hFFFF)
            op_count <= op_count + 16'd1;
`else
    assign op_count = '0;
`endif
endmodule
